keccak_padder_stream: RTL
=========================

KECCAK_PADDER_STREAM -- requirements
Module: keccak_padder_stream

Interface
REQ-001 SHALL have parameter WORD_W, default 64: input word width in bits, a multiple of 8.
REQ-002 SHALL have parameter RATE_BITS, default 1088: sponge rate, a multiple of WORD_W; WORDS = RATE_BITS/WORD_W, WB = WORD_W/8.
REQ-003 SHALL have parameter SUFFIX, default 8'h06: domain-separation byte; the package supplies values 0x01 (Keccak), 0x06 (SHA3) and 0x1F (SHAKE).
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_data, input, WORD_W: message word; valid bytes are MSB-justified.
REQ-007 SHALL have port in_byte_num, input, clog2(WB+1): count of valid bytes, 0..WB; sampled only when in_last=1.
REQ-008 SHALL have ports in_last, input, 1 (final word of the message); in_valid, input, 1; in_ready, output, 1.
REQ-009 SHALL have port out_block, output, RATE_BITS: padded block, with the first word in the MSBs.
REQ-010 SHALL have ports out_valid, output, 1; out_ready, input, 1; out_last, output, 1 (this block ends the message).

Function
REQ-011 SHALL transfer a word when in_valid && in_ready, and a block when out_valid && out_ready.
REQ-012 SHALL run the FSM FILL -> PAD -> HOLD; HOLD -> FILL or PAD on block transfer; in_ready=1 only in FILL.
REQ-013 SHALL, in FILL, write each accepted word into slot word_cnt (0..WORDS-1), at bits [RATE_BITS-1-word_cnt*WORD_W -: WORD_W], and increment word_cnt.
REQ-014 SHALL treat a word with in_last=0 as WB valid bytes, regardless of in_byte_num.
REQ-015 SHALL, for in_last=1 with in_byte_num=n<WB, keep the n MSB bytes, put SUFFIX in byte n (from the MSB) and zero the lower bytes.
REQ-016 SHALL, for in_last=1 with in_byte_num=WB, store the word unmodified and set suffix_pending.
REQ-017 SHALL, in PAD, write one slot per cycle: SUFFIX in the MSB byte with the rest zero if suffix_pending (then clear the flag), otherwise all zeros.
REQ-018 SHALL OR 8'h80 into the block LSB byte (bits [7:0]) in the cycle that fills the last slot of a message-final block; if SUFFIX also lands there the byte is SUFFIX|0x80.
REQ-019 SHALL enter HOLD the cycle after slot WORDS-1 is written; out_valid=1 only in HOLD.
REQ-020 SHALL hold out_block and out_last stable while out_valid && !out_ready.
REQ-021 SHALL, when a non-final block fills (no in_last seen), give out_last=0 and apply no 0x80 OR.
REQ-022 SHALL, when an in_last word with in_byte_num=WB fills slot WORDS-1, emit that block with out_last=0 and no 0x80.
REQ-023 SHALL, after that block transfers, go to PAD at slot 0 with suffix_pending=1, producing an extra block with out_last=1.
REQ-024 SHALL, after a final block transfers, clear the block register, word_cnt and flags and return to FILL.
REQ-025 SHALL give a latency of 1 + (WORDS-1-k) cycles from accepting the last word at slot k to out_valid.
REQ-026 SHALL reach out_valid in the cycle after acceptance when k=WORDS-1 and no extra block is needed.

Reset
REQ-027 SHALL, while rst_n=0, force state=FILL, word_cnt=0, suffix_pending=0, out_block=0, out_valid=0, out_last=0 and in_ready=0.
REQ-028 SHALL set in_ready=1 from the first clock edge after rst_n deasserts.
REQ-029 SHALL, on reset mid-FILL, mid-PAD or mid-HOLD, discard the partial or held block without emitting it.

Structure
REQ-030 SHALL place the FSM state enum and the SUFFIX_KECCAK/SUFFIX_SHA3/SUFFIX_SHAKE constants in the shared package keccak_pkg.
REQ-031 SHALL contain one combinational sub-module, keccak_word_pad (word, byte count, last, pending, suffix -> padded word), as the parametrised per-word successor of the fixed-width padder.

Verification (WORD_W=64, RATE_BITS=1088, SUFFIX=0x06 unless stated)
REQ-032 SHALL cover: empty message (one in_last word, byte_num=0) -> out_block[1087:1080]=0x06, [7:0]=0x80, rest 0, out_last=1, out_valid 17 cycles after accept.
REQ-033 SHALL cover: 16 full words plus last word byte_num=7 at slot 16 -> bits [7:0]=0x86, out_valid the next cycle, no PAD cycles.
REQ-034 SHALL cover: 17 words with the 17th in_last, byte_num=8 -> block 1 unmodified, out_last=0; block 2 = 0x06 at [1087:1080], 0x80 at [7:0], out_last=1.
REQ-035 SHALL cover: SUFFIX=0x01, slot 0 last word 0xAABBCC.., byte_num=3 -> [1087:1056]=0xAABBCC01, [7:0]=0x80.
REQ-036 SHALL cover: out_ready=0 for 5 cycles in HOLD -> out_block stable, in_ready=0; transfer on cycle 6, then in_ready=1.
REQ-037 SHALL cover: rst_n pulsed low mid-PAD -> all outputs 0 at once; the next message's block is bit-exact to the reference model.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak streaming padder.
// Holds the padder FSM state encoding and the standard domain-separation suffix bytes.
package keccak_pkg;

    typedef enum logic [1:0] {
        StFill,
        StPad,
        StHold
    } state_e;

    localparam logic [7:0] SUFFIX_KECCAK = 8'h01;
    localparam logic [7:0] SUFFIX_SHA3   = 8'h06;
    localparam logic [7:0] SUFFIX_SHAKE  = 8'h1F;

endpackage

// File: rtl/keccak_word_pad.sv
// Combinational per-word padder: trims a final word to its valid bytes and inserts the suffix.
// A pending suffix (deferred from a full final word) yields a suffix-only word.
module keccak_word_pad #(
    parameter int unsigned WORD_W = 64,
    parameter int unsigned BN_W   = $clog2(WORD_W / 8 + 1)
) (
    input  logic [WORD_W-1:0] i_word,
    input  logic [BN_W-1:0]   i_byte_num,
    input  logic              i_last,
    input  logic              i_pending,
    input  logic [7:0]        i_suffix,
    output logic [WORD_W-1:0] o_word,
    output logic              o_defer
);

    localparam int unsigned WB = WORD_W / 8;

    always_comb begin
        o_word  = i_word;
        // A full final word leaves no room for the suffix; it moves to the next slot.
        o_defer = !i_pending && i_last && (int'(i_byte_num) >= int'(WB));
        if (i_pending) begin
            o_word = {i_suffix, {(WORD_W - 8){1'b0}}};
        end else if (i_last) begin
            for (int b = 0; b < int'(WB); b++) begin
                if (b >= int'(i_byte_num)) begin
                    o_word[WORD_W-1-8*b -: 8] = (b == int'(i_byte_num)) ? i_suffix : 8'h00;
                end
            end
        end
    end

endmodule

// File: rtl/keccak_padder_stream.sv
// Streaming Keccak padder: packs MSB-first message words into rate-sized blocks and applies
// suffix/0x80 multi-rate padding, emitting each block over a valid/ready handshake.
module keccak_padder_stream
    import keccak_pkg::*;
#(
    parameter int unsigned WORD_W    = 64,
    parameter int unsigned RATE_BITS = 1088,
    parameter logic [7:0]  SUFFIX    = SUFFIX_SHA3,
    localparam int unsigned WB       = WORD_W / 8,
    localparam int unsigned BN_W     = $clog2(WB + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD_W-1:0]    in_data,
    input  logic [BN_W-1:0]      in_byte_num,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [RATE_BITS-1:0] out_block,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    localparam int unsigned WORDS = RATE_BITS / WORD_W;
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WORDS - 1);

    state_e               r_state, w_state_d;
    logic [CNT_W-1:0]     r_word_cnt, w_word_cnt_d;
    logic                 r_pending, w_pending_d;
    logic                 r_out_last, w_out_last_d;
    logic                 r_active;
    logic [RATE_BITS-1:0] r_block, w_block_d;

    logic              w_fill, w_accept, w_last_slot, w_write, w_ends, w_defer;
    logic [WORD_W-1:0] w_pad_in, w_padded, w_slot;

    assign w_fill      = (r_state == StFill);
    assign in_ready    = w_fill && r_active;
    assign w_accept    = in_valid && in_ready;
    assign w_last_slot = (r_word_cnt == LAST_SLOT);
    assign w_pad_in    = w_fill ? in_data : '0;

    assign out_block = r_block;
    assign out_valid = (r_state == StHold);
    assign out_last  = r_out_last;

    keccak_word_pad #(
        .WORD_W (WORD_W),
        .BN_W   (BN_W)
    ) u_word_pad (
        .i_word     (w_pad_in),
        .i_byte_num (in_byte_num),
        .i_last     (w_fill && in_last),
        .i_pending  (!w_fill && r_pending),
        .i_suffix   (SUFFIX),
        .o_word     (w_padded),
        .o_defer    (w_defer)
    );

    always_comb begin
        w_state_d    = r_state;
        w_word_cnt_d = r_word_cnt;
        w_pending_d  = r_pending;
        w_out_last_d = r_out_last;
        w_block_d    = r_block;
        w_write      = 1'b0;
        w_ends       = 1'b0;

        unique case (r_state)
            StFill: begin
                if (w_accept) begin
                    w_write = 1'b1;
                    if (in_last) begin
                        if (w_defer) begin
                            w_pending_d = 1'b1;
                        end else begin
                            w_ends = 1'b1;
                        end
                    end
                    if (w_last_slot) begin
                        w_state_d    = StHold;
                        w_out_last_d = w_ends;
                    end else begin
                        w_word_cnt_d = r_word_cnt + 1'b1;
                        if (in_last) begin
                            w_state_d = StPad;
                        end
                    end
                end
            end
            StPad: begin
                w_write     = 1'b1;
                w_ends      = 1'b1;
                w_pending_d = 1'b0;
                if (w_last_slot) begin
                    w_state_d    = StHold;
                    w_out_last_d = 1'b1;
                end else begin
                    w_word_cnt_d = r_word_cnt + 1'b1;
                end
            end
            StHold: begin
                if (out_ready) begin
                    w_word_cnt_d = '0;
                    w_block_d    = '0;
                    w_out_last_d = 1'b0;
                    // A deferred suffix still owes the message a padding-only block.
                    w_state_d    = (!r_out_last && r_pending) ? StPad : StFill;
                    if (r_out_last) begin
                        w_pending_d = 1'b0;
                    end
                end
            end
            default: w_state_d = StFill;
        endcase

        w_slot = w_padded;
        if (w_ends && w_last_slot) begin
            w_slot[7:0] = w_slot[7:0] | 8'h80;
        end
        if (w_write) begin
            w_block_d[RATE_BITS-1-int'(r_word_cnt)*WORD_W -: WORD_W] = w_slot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StFill;
            r_word_cnt <= '0;
            r_pending  <= 1'b0;
            r_out_last <= 1'b0;
            r_block    <= '0;
            r_active   <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_word_cnt <= w_word_cnt_d;
            r_pending  <= w_pending_d;
            r_out_last <= w_out_last_d;
            r_block    <= w_block_d;
            r_active   <= 1'b1;
        end
    end

endmodule
